// File: rtl/memory_responder_pkg.sv
// ============================================================================
// memory_responder_pkg : shared MemoryBus constants and credit helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package memory_responder_pkg;

    localparam int RESPONSE_DEPTH    = 4;
    localparam int READ_LATENCY      = 2;
    localparam int BUS_DATA_WIDTH    = 24;
    localparam int BUS_ADDRESS_WIDTH = 32;
    localparam int BUS_ID_WIDTH      = 8;
    localparam int CREDIT_WIDTH      = $clog2(RESPONSE_DEPTH + 1);

    function automatic logic [CREDIT_WIDTH-1:0] credit_next(
        input logic [CREDIT_WIDTH-1:0] current,
        input logic                    take,
        input logic                    give
    );
        logic [CREDIT_WIDTH-1:0] result;
        result = current;
        if (take && !give) begin
            result = current + CREDIT_WIDTH'(1);
        end else if (give && !take) begin
            result = current - CREDIT_WIDTH'(1);
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/memory_responder_bus.sv
// ============================================================================
// MemoryBus : request/response bundle between a master and a memory slave
// Revision: 1.0
// ============================================================================
`default_nettype none

interface MemoryBus #(
    parameter int DATA_WIDTH    = memory_responder_pkg::BUS_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = memory_responder_pkg::BUS_ADDRESS_WIDTH,
    parameter int ID_WIDTH      = memory_responder_pkg::BUS_ID_WIDTH
) ();

    logic                     mValid;
    logic                     mReady;
    logic                     mWrite;
    logic [ADDRESS_WIDTH-1:0] mAddress;
    logic [DATA_WIDTH-1:0]    mData;
    logic [ID_WIDTH-1:0]      mID;

    logic                     sValid;
    logic                     sReady;
    logic [DATA_WIDTH-1:0]    sData;
    logic [ID_WIDTH-1:0]      sID;

    modport Master (
        output mValid, mWrite, mAddress, mData, mID, sReady,
        input  mReady, sValid, sData, sID
    );

    modport Slave (
        input  mValid, mWrite, mAddress, mData, mID, sReady,
        output mReady, sValid, sData, sID
    );

endinterface

`default_nettype wire

// File: rtl/memory_responder_fifo.sv
// ============================================================================
// ResponseFifo : small first-word-fall-through FIFO for read responses
// Revision: 1.0
// ============================================================================
`default_nettype none

module ResponseFifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_q;
    logic [PTR_WIDTH-1:0]   rd_ptr_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   empty;
    logic                   full;
    logic                   do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == COUNT_WIDTH'(DEPTH));
    assign do_pop  = pop_i && !empty;
    assign valid_o = !empty;
    // Zero when empty so the response bus reads 0 out of reset
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + COUNT_WIDTH'(1);
                2'b01:   count_q <= count_q - COUNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(push_i && full && !do_pop));

endmodule

`default_nettype wire

// File: rtl/memory_responder.sv
// ============================================================================
// memory_responder : block-RAM slave on MemoryBus with credit-limited reads
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int                       DATA_WIDTH    = BUS_DATA_WIDTH,
    parameter int                       ADDRESS_WIDTH = BUS_ADDRESS_WIDTH,
    parameter int                       ID_WIDTH      = BUS_ID_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = '0,
    parameter int                       DEPTH         = 4096
) (
    input  logic    clock,
    input  logic    reset,
    MemoryBus.Slave bus
);

    localparam int INDEX_WIDTH = $clog2(DEPTH);
    localparam int FIFO_WIDTH  = ID_WIDTH + DATA_WIDTH;

    logic [ADDRESS_WIDTH-1:0] offset;
    logic [INDEX_WIDTH-1:0]   index;
    logic                     in_window;
    logic                     credits_full;
    logic                     ready;
    logic                     write_acc;
    logic                     read_acc;
    logic                     retire;
    logic [FIFO_WIDTH-1:0]    fifo_data;

    logic [DATA_WIDTH-1:0]    ram_q [DEPTH];
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     ready_en_q;
    logic                     s1_valid_q;
    logic [ID_WIDTH-1:0]      s1_id_q;
    logic                     s2_valid_q;
    logic [ID_WIDTH-1:0]      s2_id_q;
    logic [DATA_WIDTH-1:0]    s2_data_q;
    logic [CREDIT_WIDTH-1:0]  credit_q;
    logic [CREDIT_WIDTH-1:0]  credit_d;

    assign offset       = bus.mAddress - BASE_ADDRESS;
    assign index        = offset[INDEX_WIDTH-1:0];
    assign in_window    = (bus.mAddress >= BASE_ADDRESS)
                       && ({1'b0, offset} < (ADDRESS_WIDTH + 1)'(DEPTH));
    assign credits_full = (credit_q == CREDIT_WIDTH'(RESPONSE_DEPTH));
    // Writes never produce a response, so they bypass the credit limit
    assign ready        = ready_en_q && !reset && in_window
                       && (bus.mWrite || !credits_full);
    assign bus.mReady   = ready;
    assign write_acc    = bus.mValid && ready && bus.mWrite;
    assign read_acc     = bus.mValid && ready && !bus.mWrite;
    assign retire       = bus.sValid && bus.sReady;
    assign credit_d     = credit_next(credit_q, read_acc, retire);

    always_ff @(posedge clock) begin
        if (write_acc) begin
            ram_q[index] <= bus.mData;
        end
        if (read_acc) begin
            rdata_q <= ram_q[index];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ready_en_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_data_q  <= '0;
            credit_q   <= '0;
        end else begin
            ready_en_q <= 1'b1;
            s1_valid_q <= read_acc;
            s1_id_q    <= bus.mID;
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            s2_data_q  <= rdata_q;
            credit_q   <= credit_d;
        end
    end

    ResponseFifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (RESPONSE_DEPTH)
    ) u_response_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (s2_valid_q),
        .data_i  ({s2_id_q, s2_data_q}),
        .pop_i   (bus.sReady),
        .data_o  (fifo_data),
        .valid_o (bus.sValid)
    );

    assign {bus.sID, bus.sData} = fifo_data;

endmodule

`default_nettype wire

// File: tb/tb_memory_responder.sv
// ============================================================================
// tb_memory_responder : scoreboard bench for memory_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_responder;
    import memory_responder_pkg::*;

    localparam int             DW    = 24;
    localparam int             AW    = 32;
    localparam int             IW    = 8;
    localparam int             DEPTH = 64;
    localparam int             IDXW  = $clog2(DEPTH);
    localparam logic [AW-1:0]  BASE  = 32'h0000_0400;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } rsp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rand_rdy = 1'b0;
    always #5 clock = ~clock;

    MemoryBus #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) bus_if ();

    memory_responder #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .ID_WIDTH      (IW),
        .BASE_ADDRESS  (BASE),
        .DEPTH         (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    rsp_t          exp_q [$];
    logic [DW-1:0] model [DEPTH];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            rsp_seen = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: model updates and expected pushes on accepts, compares on retires
    initial begin
        rsp_t          e;
        logic [AW-1:0] off;
        logic          hold;
        logic [IW+DW-1:0] hold_val;
        hold = 1'b0;
        hold_val = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk_eq("hold_valid", bus_if.sValid, 1);
                    chk_eq("hold_payload", {bus_if.sID, bus_if.sData}, hold_val);
                end
                if (bus_if.sValid && bus_if.sReady) begin
                    if (exp_q.size() == 0) begin
                        chk_eq("spurious_rsp", bus_if.sValid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk_eq("rsp_data", bus_if.sData, e.data);
                        chk_eq("rsp_id", bus_if.sID, e.id);
                        rsp_seen++;
                    end
                end
                if (bus_if.mValid && bus_if.mReady) begin
                    off = bus_if.mAddress - BASE;
                    chk_eq("accept_window", (bus_if.mAddress >= BASE) && (off < AW'(DEPTH)), 1);
                    if (bus_if.mWrite) model[off[IDXW-1:0]] = bus_if.mData;
                    else exp_q.push_back({bus_if.mID, model[off[IDXW-1:0]]});
                end
                hold = bus_if.sValid && !bus_if.sReady;
                hold_val = {bus_if.sID, bus_if.sData};
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_rdy) bus_if.sReady = 1'($urandom);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called #1 after a rising edge; returns #1 after the accept edge or after budget cycles
    task automatic req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [IW-1:0] id, input int budget, output logic acc);
        bus_if.mValid   = 1'b1;
        bus_if.mWrite   = wr;
        bus_if.mAddress = addr;
        bus_if.mData    = data;
        bus_if.mID      = id;
        acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clock);
            acc = bus_if.mReady;
            @(posedge clock);
            #1;
        end
        bus_if.mValid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        logic acc;
        logic wr;
        int   off;
        int   seen0;
        bus_if.mValid   = 1'b0;
        bus_if.mWrite   = 1'b0;
        bus_if.mAddress = '0;
        bus_if.mData    = '0;
        bus_if.mID      = '0;
        bus_if.sReady   = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk_eq("rst_mready", bus_if.mReady, 0);
        chk_eq("rst_svalid", bus_if.sValid, 0);
        chk_eq("rst_sdata", bus_if.sData, 0);
        chk_eq("rst_sid", bus_if.sID, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus_if.mWrite   = 1'b1;
        bus_if.mAddress = BASE;
        @(negedge clock);
        chk_eq("ready_first_cycle", bus_if.mReady, 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk_eq("ready_second_cycle", bus_if.mReady, 1);
        @(posedge clock);
        #1;

        for (int i = 0; i < DEPTH; i++) begin
            req(1'b1, BASE + AW'(i), DW'($urandom), '0, 4, acc);
            chk_eq("init_wr", acc, 1);
        end

        // Write then read the same word on the next cycle
        req(1'b1, BASE + 5, 24'h123456, '0, 4, acc);
        chk_eq("t34_wr_acc", acc, 1);
        req(1'b0, BASE + 5, '0, 8'h07, 1, acc);
        chk_eq("t34_rd_acc", acc, 1);
        for (int c = 1; c <= READ_LATENCY; c++) begin
            @(negedge clock);
            chk_eq("t34_early_svalid", bus_if.sValid, 0);
        end
        @(negedge clock);
        chk_eq("t34_svalid", bus_if.sValid, 1);
        chk_eq("t34_sdata", bus_if.sData, 24'h123456);
        chk_eq("t34_sid", bus_if.sID, 8'h07);
        @(posedge clock);
        #1;
        drain("t34_drain");

        // Credit limit with stalled responses, write still accepted when full
        bus_if.sReady = 1'b0;
        seen0 = rsp_seen;
        for (int k = 0; k < 4; k++) begin
            req(1'b0, BASE + AW'(10 + k), '0, IW'(8'h20 + k), 1, acc);
            chk_eq("t35_rd_acc", acc, 1);
        end
        req(1'b0, BASE + 14, '0, 8'h24, 4, acc);
        chk_eq("t35_rd_blocked", acc, 0);
        req(1'b1, BASE + 9, 24'hABCDEF, '0, 2, acc);
        chk_eq("t37_wr_when_full", acc, 1);
        bus_if.sReady = 1'b1;
        req(1'b0, BASE + 14, '0, 8'h24, 10, acc);
        chk_eq("t35_rd5_acc", acc, 1);
        req(1'b0, BASE + 15, '0, 8'h25, 10, acc);
        chk_eq("t35_rd6_acc", acc, 1);
        req(1'b0, BASE + 9, '0, 8'h30, 10, acc);
        chk_eq("t37_rd_acc", acc, 1);
        drain("t35_drain");
        chk_eq("t35_rsp_count", rsp_seen - seen0, 7);

        // Addresses just outside the window are never claimed
        bus_if.mValid   = 1'b1;
        bus_if.mWrite   = 1'b0;
        bus_if.mAddress = BASE + AW'(DEPTH);
        bus_if.mID      = 8'h55;
        repeat (5) begin
            @(negedge clock);
            chk_eq("t36_ready_above", bus_if.mReady, 0);
        end
        bus_if.mAddress = BASE - 1;
        @(negedge clock);
        chk_eq("t36_ready_below", bus_if.mReady, 0);
        @(posedge clock);
        #1;
        bus_if.mValid = 1'b0;
        repeat (6) begin
            @(negedge clock);
            chk_eq("t36_no_rsp", bus_if.sValid, 0);
        end
        @(posedge clock);
        #1;
        req(1'b0, BASE + AW'(DEPTH - 1), '0, 8'h3F, 2, acc);
        chk_eq("t36_top_word_acc", acc, 1);
        drain("t36_drain");

        // Reset lands while two reads are in flight
        req(1'b0, BASE + 1, '0, 8'h41, 2, acc);
        chk_eq("t38_rd1_acc", acc, 1);
        req(1'b0, BASE + 2, '0, 8'h42, 1, acc);
        chk_eq("t38_rd2_acc", acc, 1);
        reset = 1'b1;
        bus_if.mValid   = 1'b1;
        bus_if.mAddress = BASE + 3;
        @(negedge clock);
        chk_eq("t38_mready_rst", bus_if.mReady, 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk_eq("t38_mready_rst2", bus_if.mReady, 0);
        chk_eq("t38_svalid_rst", bus_if.sValid, 0);
        chk_eq("t38_sdata_rst", bus_if.sData, 0);
        chk_eq("t38_sid_rst", bus_if.sID, 0);
        @(posedge clock);
        #1;
        bus_if.mValid = 1'b0;
        reset = 1'b0;
        repeat (8) begin
            @(negedge clock);
            chk_eq("t38_no_rsp", bus_if.sValid, 0);
        end
        @(posedge clock);
        #1;

        // Random traffic with random response backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            wr  = ($urandom_range(0, 2) == 0);
            off = int'($urandom_range(0, DEPTH - 1));
            req(wr, BASE + AW'(off), DW'($urandom), IW'($urandom), 50, acc);
            chk_eq("t39_acc", acc, 1);
        end
        rand_rdy = 1'b0;
        bus_if.sReady = 1'b1;
        drain("t39_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 24, sets the word width of the memory and bus data.
REQ-002 Parameter ADDRESS_WIDTH, default 32, sets the bus address width.
REQ-003 Parameter ID_WIDTH, default 8, sets the master-ID field width.
REQ-004 Parameter BASE_ADDRESS, default 0, sets the first word address served.
REQ-005 Parameter DEPTH, default 4096, sets the number of words stored; it SHALL be a power of two.
REQ-006 Port clock  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-007 Port reset  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-008 Port bus  MemoryBus.Slave  (bundle)  is the request/response port serving a MemoryBus.Master such as the ray unit.
REQ-009 The request fields used SHALL be mValid, mReady (driven by this block), mWrite, mAddress[ADDRESS_WIDTH], mData[DATA_WIDTH] and mID[ID_WIDTH].
REQ-010 The response fields used SHALL be sValid (driven by this block), sReady, sData[DATA_WIDTH] and sID[ID_WIDTH].

Function
REQ-011 A request SHALL be accepted on any cycle where mValid and mReady are both high.
REQ-012 The block SHALL claim only addresses in BASE_ADDRESS to BASE_ADDRESS+DEPTH-1; mReady SHALL stay low for any other address.
REQ-013 An accepted write SHALL store mData at index (mAddress-BASE_ADDRESS) at the accept edge and SHALL generate no response.
REQ-014 An accepted read SHALL pass through a 2-stage pipeline: registered RAM read, then output register.
REQ-015 With sReady held high, sValid for a read SHALL assert exactly 2 cycles after the accept edge, carrying the stored word and the request mID.
REQ-016 Responses SHALL return in acceptance order.
REQ-017 Responses SHALL enter a 4-entry response FIFO; sValid SHALL equal FIFO not-empty.
REQ-018 A response SHALL retire when sValid and sReady are both high.
REQ-019 A credit counter SHALL track reads in flight in the pipeline plus FIFO occupancy, ranging 0..4.
REQ-020 mReady SHALL be low for reads when credits equal 4; writes SHALL still be accepted in that condition.
REQ-021 When an accept and a retire occur on the same cycle, the credit count SHALL be unchanged.
REQ-022 A read and a write to the same address in different cycles SHALL be ordered, so a read accepted the cycle after a write returns the new data.
REQ-023 sData and sID SHALL hold stable while sValid is high and sReady is low.
REQ-024 Reads reaching the FIFO SHALL never be dropped.
REQ-025 Overflowing the FIFO SHALL be unreachable and SHALL be flagged by an assertion.

Reset
REQ-026 While reset is high, mReady=0, sValid=0, sData=0, sID=0 and the credit count is 0.
REQ-027 Reset SHALL empty the FIFO and the pipeline.
REQ-028 Reads in flight when reset asserts SHALL be discarded without any response.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 mReady SHALL first rise on the cycle after reset deasserts.

Structure
REQ-031 The constants RESPONSE_DEPTH=4 and READ_LATENCY=2 and the request/response field widths SHALL live in the shared bus package used by MemoryBus.
REQ-032 The response FIFO SHALL be a sub-module named ResponseFifo, parameterised by width and depth.
REQ-033 The RAM SHALL be an inferred simple-dual-port block RAM with no reset.

Verification
REQ-034 Write 0x123456 to BASE+5, then read BASE+5 with ID 0x07 on the next cycle -> sValid 2 cycles later with sData=0x123456 and sID=0x07.
REQ-035 Hold sReady=0 and issue 6 back-to-back reads -> exactly 4 are accepted, then mReady goes low for reads; raising sReady returns all 4 in order and the last 2 are then accepted.
REQ-036 Request address BASE+DEPTH -> mReady stays 0 and no response is produced.
REQ-037 With credits full, issue a write -> the write is accepted and a later read returns the written value.
REQ-038 Assert reset 1 cycle after accepting 2 reads -> no sValid ever appears for them and mReady=0 during reset.
REQ-039 Stream 1000 random reads and writes with random sReady -> returned data and IDs match a reference model in order, with no overflow assertion.
